// File: rtl/map_pkg.sv
// Shared map definitions: geometry of the 30x160-bit map RAM and the tile encoding
// used by the VGA, pacman and ghost controllers.
package map_pkg;

   localparam int unsigned MAP_COLS = 40;
   localparam int unsigned MAP_ROWS = 30;
   localparam int unsigned TILE_W   = 4;
   localparam int unsigned ROW_W    = MAP_COLS * TILE_W;

   typedef logic [TILE_W-1:0] tile_t;

   typedef enum logic [TILE_W-1:0] {
      TileEmpty  = 4'h0,
      TileWall   = 4'h1,
      TilePill   = 4'h2,
      TilePower  = 4'h3,
      TilePacman = 4'h4,
      TileGhost  = 4'h5
   } tile_code_e;

   // Column 0 is the most significant nibble of a row.
   function automatic tile_t get_tile(input logic [ROW_W-1:0] row, input int unsigned col);
      return row[ROW_W - TILE_W - TILE_W * col +: TILE_W];
   endfunction

   function automatic logic [ROW_W-1:0] set_tile(input logic [ROW_W-1:0] row,
                                                  input int unsigned      col,
                                                  input tile_t            tile);
      logic [ROW_W-1:0] r;
      r = row;
      r[ROW_W - TILE_W - TILE_W * col +: TILE_W] = tile;
      return r;
   endfunction

endpackage

// File: rtl/map_port_arbiter_if.sv
// Requester handshake and map RAM port-B signals of the map port arbiter.
interface map_port_arbiter_if #(
   parameter int unsigned N_REQ = 3
);

   logic [N_REQ-1:0]          req;
   logic [6*N_REQ-1:0]        req_x;
   logic [5*N_REQ-1:0]        req_y;
   logic [4*N_REQ-1:0]        req_tile;
   logic [N_REQ-1:0]          ack;
   logic [3:0]                old_tile;
   logic                      err;
   logic                      busy;
   logic [4:0]                ram_addr;
   logic                      ram_wren;
   logic [map_pkg::ROW_W-1:0] ram_wrdata;
   logic [map_pkg::ROW_W-1:0] ram_rddata;

   modport master (
      output req, req_x, req_y, req_tile, ram_rddata,
      input  ack, old_tile, err, busy, ram_addr, ram_wren, ram_wrdata
   );

   modport slave (
      input  req, req_x, req_y, req_tile, ram_rddata,
      output ack, old_tile, err, busy, ram_addr, ram_wren, ram_wrdata
   );

endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: the search starts one past ptr_i and returns a one-hot
// grant plus its index.
module rr_arbiter #(
   parameter int unsigned NumReq = 3,
   parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              valid_o
);

   always_comb begin
      int unsigned cand;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned off = 1; off <= NumReq; off++) begin
         cand = (32'(ptr_i) + off) % NumReq;
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = IdxW'(cand);
         end
      end
      if (valid_o) begin
         gnt_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/map_port_arbiter.sv
// Round-robin read-modify-write arbiter for port B of the map RAM; returns the
// previous tile of every update so callers can detect collisions.
module map_port_arbiter
   import map_pkg::*;
#(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned COLS   = 40,
   parameter int unsigned ROWS   = 30
) (
   input logic             CLOCK_50,
   input logic             reset_n,
   map_port_arbiter_if.slave bus
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRead  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StAck   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic [IdxW-1:0]  win_idx_q, win_idx_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [5:0]       x_q, x_d;
   logic [4:0]       y_q, y_d;
   tile_t            tile_q, tile_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [4:0]       ram_addr_q, ram_addr_d;
   logic             ram_wren_q, ram_wren_d;
   logic [ROW_W-1:0] ram_wrdata_q, ram_wrdata_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   tile_t            old_tile_q, old_tile_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] gnt;
   logic [IdxW-1:0]  gnt_idx;
   logic             gnt_valid;
   logic [5:0]       sel_x;
   logic [4:0]       sel_y;
   tile_t            sel_tile;
   logic             sel_oor;

   rr_arbiter #(
      .NumReq (N_REQ),
      .IdxW   (IdxW)
   ) u_rr_arbiter (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign sel_x    = bus.req_x[6 * 32'(gnt_idx) +: 6];
   assign sel_y    = bus.req_y[5 * 32'(gnt_idx) +: 5];
   assign sel_tile = bus.req_tile[4 * 32'(gnt_idx) +: 4];
   assign sel_oor  = (32'(sel_x) >= COLS) || (32'(sel_y) >= ROWS);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      win_idx_d    = win_idx_q;
      cnt_d        = cnt_q;
      x_d          = x_q;
      y_d          = y_q;
      tile_d       = tile_q;
      row_d        = row_q;
      ram_addr_d   = ram_addr_q;
      ram_wrdata_d = ram_wrdata_q;
      ram_wren_d   = 1'b0;
      ack_d        = '0;
      old_tile_d   = '0;
      err_d        = 1'b0;

      case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               win_idx_d = gnt_idx;
               x_d       = sel_x;
               y_d       = sel_y;
               tile_d    = sel_tile;
               // Out-of-range requests never touch the RAM.
               if (sel_oor) begin
                  ack_d   = gnt;
                  err_d   = 1'b1;
                  state_d = StAck;
               end else begin
                  ram_addr_d = sel_y;
                  cnt_d      = '0;
                  state_d    = StRead;
               end
            end
         end
         StRead: begin
            if (cnt_q == CntW'(RD_LAT - 1)) begin
               row_d        = bus.ram_rddata;
               ram_wrdata_d = set_tile(bus.ram_rddata, 32'(x_q), tile_q);
               ram_wren_d   = 1'b1;
               state_d      = StWrite;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWrite: begin
            ack_d[win_idx_q] = 1'b1;
            old_tile_d       = get_tile(row_q, 32'(x_q));
            state_d          = StAck;
         end
         StAck: begin
            ptr_d   = win_idx_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         ptr_q        <= IdxW'(N_REQ - 1);
         win_idx_q    <= '0;
         cnt_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         tile_q       <= '0;
         row_q        <= '0;
         ram_addr_q   <= '0;
         ram_wren_q   <= 1'b0;
         ram_wrdata_q <= '0;
         ack_q        <= '0;
         old_tile_q   <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         win_idx_q    <= win_idx_d;
         cnt_q        <= cnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         tile_q       <= tile_d;
         row_q        <= row_d;
         ram_addr_q   <= ram_addr_d;
         ram_wren_q   <= ram_wren_d;
         ram_wrdata_q <= ram_wrdata_d;
         ack_q        <= ack_d;
         old_tile_q   <= old_tile_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.old_tile   = old_tile_q;
   assign bus.err        = err_q;
   assign bus.busy       = busy_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wren   = ram_wren_q;
   assign bus.ram_wrdata = ram_wrdata_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboard bench for map_port_arbiter: a RD_LAT=2 instance runs the main scenarios and a
// RD_LAT=1 instance reruns the single-request case.
module tb_map_port_arbiter;
   import map_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic reset_n  = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   map_port_arbiter_if #(.N_REQ(3)) bus0 ();
   map_port_arbiter_if #(.N_REQ(3)) bus1 ();

   map_port_arbiter #(.N_REQ(3), .RD_LAT(2), .COLS(40), .ROWS(30)) dut0 (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .bus      (bus0)
   );

   map_port_arbiter #(.N_REQ(3), .RD_LAT(1), .COLS(40), .ROWS(30)) dut1 (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .bus      (bus1)
   );

   // Map RAM models: registered read for RD_LAT=2, direct read for RD_LAT=1.
   logic [ROW_W-1:0] mem0 [32];
   logic [ROW_W-1:0] mem1 [32];
   logic [ROW_W-1:0] rd0;
   int unsigned      wren_cnt0 = 0;
   int unsigned      cyc = 0;

   always @(posedge CLOCK_50) begin
      cyc <= cyc + 1;
      rd0 <= mem0[bus0.ram_addr];
      if (bus0.ram_wren) begin
         mem0[bus0.ram_addr] = bus0.ram_wrdata;
         wren_cnt0++;
      end
      if (bus1.ram_wren) mem1[bus1.ram_addr] = bus1.ram_wrdata;
   end
   assign bus0.ram_rddata = rd0;
   assign bus1.ram_rddata = mem1[bus1.ram_addr];

   typedef struct {
      int unsigned idx;
      tile_t       old;
      logic        err;
      int unsigned at;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [ROW_W-1:0] act,
                      input logic [ROW_W-1:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, want);
   endtask

   task automatic push(input int d, input int unsigned idx, input tile_t old, input logic err,
                       input int unsigned at);
      exp_t e;
      e.idx = idx; e.old = old; e.err = err; e.at = at;
      if (d == 0) sb0.push_back(e);
      else sb1.push_back(e);
   endtask

   task automatic mon(input int d, input logic [2:0] ack, input tile_t old, input logic err);
      exp_t       e;
      logic [2:0] oh;
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
         n_checks++;
         $display("FAIL unexpected_ack dut%0d: got ack %b, required none", d, ack);
         return;
      end
      if (d == 0) e = sb0.pop_front();
      else e = sb1.pop_front();
      oh = 3'b001 << e.idx;
      chk($sformatf("ack_vec dut%0d", d), ack, oh);
      chk($sformatf("old_tile dut%0d idx%0d", d, e.idx), old, e.old);
      chk($sformatf("err dut%0d idx%0d", d, e.idx), err, e.err);
      chk($sformatf("ack_cycle dut%0d idx%0d", d, e.idx), cyc, e.at);
   endtask

   always @(negedge CLOCK_50) begin
      if (bus0.ack != '0) mon(0, bus0.ack, bus0.old_tile, bus0.err);
      if (bus1.ack != '0) mon(1, bus1.ack, bus1.old_tile, bus1.err);
   end

   task automatic set_op(input int d, input int i, input logic [5:0] x, input logic [4:0] y,
                         input tile_t t);
      if (d == 0) begin
         bus0.req_x[6*i +: 6]    = x;
         bus0.req_y[5*i +: 5]    = y;
         bus0.req_tile[4*i +: 4] = t;
      end else begin
         bus1.req_x[6*i +: 6]    = x;
         bus1.req_y[5*i +: 5]    = y;
         bus1.req_tile[4*i +: 4] = t;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " outs dut0"}, {bus0.ack, bus0.old_tile, bus0.err, bus0.busy, bus0.ram_addr,
                                bus0.ram_wren}, '0);
      chk({tag, " wrdata dut0"}, bus0.ram_wrdata, '0);
      chk({tag, " outs dut1"}, {bus1.ack, bus1.old_tile, bus1.err, bus1.busy, bus1.ram_addr,
                                bus1.ram_wren}, '0);
      chk({tag, " wrdata dut1"}, bus1.ram_wrdata, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
      $fatal(1);
   end

   initial begin
      int unsigned c;
      int unsigned w;
      bus0.req = '0; bus0.req_x = '0; bus0.req_y = '0; bus0.req_tile = '0;
      bus1.req = '0; bus1.req_x = '0; bus1.req_y = '0; bus1.req_tile = '0;
      for (int i = 0; i < 32; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      mem0[5] = {40{4'h1}};
      mem0[7] = {40{4'hA}};
      mem1[5] = {40{4'h1}};

      repeat (3) @(negedge CLOCK_50);
      chk_zero("in_reset");
      reset_n = 1'b1;
      @(negedge CLOCK_50);
      chk_zero("after_reset");

      // Fairness: three requesters held high for six transactions on row 2.
      set_op(0, 0, 6'd1, 5'd2, 4'h5);
      set_op(0, 1, 6'd2, 5'd2, 4'h6);
      set_op(0, 2, 6'd3, 5'd2, 4'h7);
      c = cyc;
      bus0.req = 3'b111;
      for (int k = 0; k < 6; k++)
         push(0, k % 3, (k < 3) ? 4'h0 : tile_t'(5 + k % 3), 1'b0, c + 4 + 5 * k);
      repeat (29) @(negedge CLOCK_50);
      bus0.req = '0;
      repeat (2) @(negedge CLOCK_50);
      chk("fair_row2", mem0[2], {4'h0, 4'h5, 4'h6, 4'h7, {36{4'h0}}});

      // Single request, RD_LAT=2.
      set_op(0, 0, 6'd0, 5'd5, 4'h4);
      c = cyc;
      bus0.req[0] = 1'b1;
      push(0, 0, 4'h1, 1'b0, c + 4);
      @(negedge CLOCK_50);
      chk("single_busy", bus0.busy, 1'b1);
      chk("single_addr_c1", bus0.ram_addr, 5'd5);
      @(negedge CLOCK_50);
      chk("single_nowr_c2", bus0.ram_wren, 1'b0);
      @(negedge CLOCK_50);
      chk("single_wren_c3", bus0.ram_wren, 1'b1);
      chk("single_addr_c3", bus0.ram_addr, 5'd5);
      chk("single_wrdata", bus0.ram_wrdata, {4'h4, {39{4'h1}}});
      @(negedge CLOCK_50);
      bus0.req[0] = 1'b0;
      @(negedge CLOCK_50);

      // Single request, RD_LAT=1.
      set_op(1, 0, 6'd0, 5'd5, 4'h4);
      c = cyc;
      bus1.req[0] = 1'b1;
      push(1, 0, 4'h1, 1'b0, c + 3);
      repeat (2) @(negedge CLOCK_50);
      chk("lat1_wren_c2", bus1.ram_wren, 1'b1);
      chk("lat1_wrdata", bus1.ram_wrdata, {4'h4, {39{4'h1}}});
      @(negedge CLOCK_50);
      bus1.req[0] = 1'b0;
      repeat (2) @(negedge CLOCK_50);

      // Same-row merge on row 7.
      set_op(0, 1, 6'd39, 5'd7, 4'h2);
      set_op(0, 2, 6'd38, 5'd7, 4'h3);
      c = cyc;
      bus0.req = 3'b110;
      push(0, 1, 4'hA, 1'b0, c + 4);
      push(0, 2, 4'hA, 1'b0, c + 9);
      repeat (4) @(negedge CLOCK_50);
      bus0.req[1] = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      bus0.req[2] = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      chk("merge_row7", mem0[7], {{38{4'hA}}, 4'h3, 4'h2});

      // Out-of-range x, then out-of-range y.
      w = wren_cnt0;
      set_op(0, 0, 6'd40, 5'd0, 4'hF);
      c = cyc;
      bus0.req[0] = 1'b1;
      push(0, 0, 4'h0, 1'b1, c + 1);
      @(negedge CLOCK_50);
      bus0.req[0] = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      set_op(0, 0, 6'd0, 5'd30, 4'hF);
      c = cyc;
      bus0.req[0] = 1'b1;
      push(0, 0, 4'h0, 1'b1, c + 1);
      @(negedge CLOCK_50);
      bus0.req[0] = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      chk("oor_no_write", wren_cnt0, w);

      // Reset during WRITE: the write and the ack must both be lost.
      set_op(0, 0, 6'd3, 5'd5, 4'h9);
      bus0.req[0] = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      chk("pre_reset_wren", bus0.ram_wren, 1'b1);
      #2 reset_n = 1'b0;
      #1 chk_zero("mid_op_reset");
      bus0.req[0] = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      reset_n = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      c = cyc;
      bus0.req[0] = 1'b1;
      push(0, 0, 4'h1, 1'b0, c + 4);
      repeat (4) @(negedge CLOCK_50);
      bus0.req[0] = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      chk("retry_row5", mem0[5], {4'h4, 4'h1, 4'h1, 4'h9, {36{4'h1}}});

      repeat (5) @(negedge CLOCK_50);
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
